top: RTL and testbench
======================

TOP -- requirements
Module: top

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named aclk and arst_n.
REQ-002 The block SHALL have port aclk, input, 1 bit: the single clock; all flops update on its rising edge.
REQ-003 The block SHALL have port arst_n, input, 1 bit: asynchronous active-low reset for all state.
REQ-004 The block SHALL have port adata, input, 8 bits: source data word, sampled only at an accepted send.
REQ-005 The block SHALL have port asend, input, 1 bit: source send request.
REQ-006 The block SHALL have port aready, output, 1 bit: source side idle, so a new word can be accepted.
REQ-007 The block SHALL have port bload, input, 1 bit: sink consume strobe.
REQ-008 The block SHALL have port dout, output, 8 bits: delivered data word, registered.
REQ-009 The block SHALL have port bvalid, output, 1 bit: dout holds an unconsumed word.

Function
REQ-010 The block SHALL transfer words from its source half to its sink half with a toggle req/ack handshake; each direction SHALL cross through a 3-flop chain (2 synchronizer flops plus 1 edge-detect flop).
REQ-011 A send SHALL be accepted at a rising edge where asend=1 and aready=1; at that edge hold_reg<=adata, req toggles and aready<=0.
REQ-012 asend while aready=0 SHALL be ignored; hold_reg SHALL stay stable until the transfer is acknowledged.
REQ-013 The sink SHALL detect a req toggle when sync stage 2 differs from stage 3.
REQ-014 A send accepted at edge k SHALL give dout<=hold_reg and bvalid<=1 at edge k+3.
REQ-015 A consume SHALL occur at an edge where bvalid=1 and bload=1; at that edge bvalid<=0 and ack toggles.
REQ-016 bload while bvalid=0 SHALL be ignored.
REQ-017 dout SHALL keep its last value after a consume until the next delivery.
REQ-018 An ack toggle made at edge m SHALL set aready<=1 at edge m+3.
REQ-019 With asend=1 and bload=1 held, the block SHALL accept a word every 8 cycles:
- accept k
- bvalid k+3
- consume k+4
- aready k+7
- next accept k+8
REQ-020 At most one word SHALL be in flight; no word SHALL be lost or duplicated.
REQ-021 Accept and consume in the same cycle SHALL be impossible, because aready=0 whenever bvalid=1.
REQ-022 Source state machine:
- states IDLE (aready=1) and BUSY (aready=0)
- IDLE->BUSY on an accepted send
- BUSY->IDLE on a detected ack toggle
REQ-023 Sink state machine:
- states EMPTY (bvalid=0) and FULL (bvalid=1)
- EMPTY->FULL on a detected req toggle
- FULL->EMPTY on a consume

Reset
REQ-024 While arst_n=0, the block SHALL force:
- aready=1
- bvalid=0
- dout=8'h00
- hold_reg=0
- req, ack and all synchronizer flops to 0
REQ-025 Reset SHALL take effect immediately, independent of aclk.
REQ-026 Reset asserted mid-transfer SHALL abort the transfer; no stale word SHALL appear after release.
REQ-027 Operation SHALL resume on the first rising edge after arst_n goes high.

Verification
REQ-028 Scenario reset: hold arst_n=0 -> aready=1, bvalid=0, dout=00.
REQ-029 Scenario single transfer: adata=8'hA5, asend pulsed one cycle at edge k, bload=0 -> bvalid=1 and dout=A5 after edge k+3; aready stays 0; bvalid stays 1 indefinitely.
REQ-030 Scenario consume: from the previous scenario, pulse bload -> bvalid=0 next edge, dout stays A5, aready=1 three edges later.
REQ-031 Scenario streaming: asend=bload=1 held, adata changing every 5 cycles -> transfers 8 cycles apart; each dout equals adata sampled at its accept edge; no value skipped or repeated between accepts.
REQ-032 Scenario ignored inputs: asend pulses while aready=0 and bload pulses while bvalid=0 -> no state change; hold_reg and dout unchanged.
REQ-033 Scenario reset mid-transfer: assert arst_n between accept and delivery -> all outputs return to reset values; after release, bvalid stays 0 until a new send.

Source files
------------

// File: rtl/top.sv
// top: single-word toggle req/ack handshake transfer from source half to sink half
module top (
  input  logic       aclk,
  input  logic       arst_n,
  input  logic [7:0] adata,
  input  logic       asend,
  output logic       aready,
  input  logic       bload,
  output logic [7:0] dout,
  output logic       bvalid
);
  typedef enum logic {IDLE, BUSY} src_t;
  typedef enum logic {EMPTY, FULL} snk_t;
  src_t src, src_nx;
  snk_t snk, snk_nx;
  logic req, ack;
  logic [2:0] req_sync, ack_sync;
  logic [7:0] hold_reg;
  logic accept, consume, req_seen, ack_seen;
  assign aready   = (src == IDLE);
  assign bvalid   = (snk == FULL);
  assign accept   = asend & aready;
  assign consume  = bload & bvalid;
  assign req_seen = req_sync[1] ^ req_sync[2];
  assign ack_seen = ack_sync[1] ^ ack_sync[2];
  // source half: state, held word, req toggle and ack synchronizer
  always_ff @(posedge aclk or negedge arst_n)
    if (!arst_n) begin
      src      <= IDLE;
      hold_reg <= 8'h00;
      req      <= 1'b0;
      ack_sync <= 3'b000;
    end else begin
      src      <= src_nx;
      ack_sync <= {ack_sync[1:0], ack};
      if (accept) begin
        hold_reg <= adata;
        req      <= ~req;
      end
    end
  // sink half: state, delivered word, ack toggle and req synchronizer
  always_ff @(posedge aclk or negedge arst_n)
    if (!arst_n) begin
      snk      <= EMPTY;
      dout     <= 8'h00;
      ack      <= 1'b0;
      req_sync <= 3'b000;
    end else begin
      snk      <= snk_nx;
      req_sync <= {req_sync[1:0], req};
      if (req_seen) dout <= hold_reg;
      if (consume) ack <= ~ack;
    end
  // next-state logic for both halves
  always_comb begin
    src_nx = src;
    snk_nx = snk;
    src_nx = (src == IDLE) ? (asend ? BUSY : IDLE) : (ack_seen ? IDLE : BUSY);
    snk_nx = (snk == EMPTY) ? (req_seen ? FULL : EMPTY) : (bload ? EMPTY : FULL);
  end
endmodule

// File: tb/tb_top.sv
// tb_top: randomized bench for top against a cycle-scheduled transaction model
module tb_top;
  logic       aclk = 1'b0;
  logic       arst_n = 1'b0;
  logic [7:0] adata = 8'h00;
  logic       asend = 1'b0;
  logic       bload = 1'b0;
  logic       aready, bvalid;
  logic [7:0] dout;

  int checks = 0, errors = 0;
  int cyc = 0, deliver_at = -1, ready_at = -1, last_acc = -1;
  bit m_ready = 1'b1, m_valid = 1'b0, streaming = 1'b0;
  logic [7:0] m_dout = 8'h00, pend = 8'h00;

  top dut (.aclk(aclk), .arst_n(arst_n), .adata(adata), .asend(asend),
           .aready(aready), .bload(bload), .dout(dout), .bvalid(bvalid));

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic compare_all();
    check("aready", int'(aready), int'(m_ready));
    check("bvalid", int'(bvalid), int'(m_valid));
    check("dout", int'(dout), int'(m_dout));
  endtask

  task automatic model_reset();
    m_ready = 1'b1;
    m_valid = 1'b0;
    m_dout = 8'h00;
    deliver_at = -1;
    ready_at = -1;
    last_acc = -1;
  endtask

  task automatic step(input logic [7:0] d, input logic s, input logic l);
    bit acc, con;
    adata = d;
    asend = s;
    bload = l;
    @(posedge aclk);
    cyc++;
    acc = s && m_ready;
    con = l && m_valid;
    if (acc) begin
      if (streaming && last_acc >= 0) check("gap", cyc - last_acc, 8);
      last_acc = cyc;
      pend = d;
      m_ready = 1'b0;
      deliver_at = cyc + 3;
    end
    if (cyc == deliver_at) begin
      m_valid = 1'b1;
      m_dout = pend;
    end
    if (con) begin
      m_valid = 1'b0;
      ready_at = cyc + 3;
    end
    if (cyc == ready_at) m_ready = 1'b1;
    @(negedge aclk);
    compare_all();
  endtask

  task automatic pulse_reset();
    arst_n = 1'b0;
    #2;
    check("rst_aready", int'(aready), 1);
    check("rst_bvalid", int'(bvalid), 0);
    check("rst_dout", int'(dout), 0);
    model_reset();
    @(negedge aclk);
    arst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] word;
    @(negedge aclk);
    @(negedge aclk);
    check("init_aready", int'(aready), 1);
    check("init_bvalid", int'(bvalid), 0);
    check("init_dout", int'(dout), 0);
    arst_n = 1'b1;
    step(8'h00, 1'b0, 1'b0);
    step(8'hA5, 1'b1, 1'b0);
    check("a5_busy", int'(aready), 0);
    step(8'h3C, 1'b1, 1'b0);
    step(8'h3C, 1'b0, 1'b0);
    check("a5_early", int'(bvalid), 0);
    step(8'h00, 1'b0, 1'b1);
    check("a5_valid", int'(bvalid), 1);
    check("a5_dout", int'(dout), 8'hA5);
    for (int i = 0; i < 10; i++) step(8'h77, 1'b1, 1'b0);
    check("a5_held", int'(dout), 8'hA5);
    step(8'h00, 1'b0, 1'b1);
    check("a5_consumed", int'(bvalid), 0);
    check("a5_kept", int'(dout), 8'hA5);
    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b0);
    check("a5_ready", int'(aready), 1);
    streaming = 1'b1;
    last_acc = -1;
    word = 8'($urandom);
    for (int i = 0; i < 80; i++) begin
      if (cyc % 5 == 0) word = 8'($urandom);
      step(word, 1'b1, 1'b1);
    end
    streaming = 1'b0;
    step(8'h5A, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    pulse_reset();
    for (int i = 0; i < 8; i++) step(8'($urandom), 1'b0, 1'($urandom));
    check("no_stale", int'(bvalid), 0);
    for (int p = 0; p < 6; p++) begin
      int ps = (p * 17 + 10) % 100, pl = (p * 31 + 20) % 100;
      for (int i = 0; i < 150; i++) begin
        step(8'($urandom), 1'($urandom_range(99) < ps), 1'($urandom_range(99) < pl));
        if (i == 75 && p % 2 == 1) pulse_reset();
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
